// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and small-sigma helpers for the schedule and round engine.
// Pure declarations; no timing, no backpressure.
package sha256_pkg;

    localparam int SHA256_WINDOW = 16;
    localparam int SHA256_ROUNDS = 64;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0_small(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1_small(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Next schedule word: sigma1(w14) + w9 + sigma0(w1) + w0, modulo 2^32.
// Purely combinational, zero latency; no backpressure. Kept separate so it can be retimed.
module sha256_sched_word
    import sha256_pkg::*;
(
    input  logic [31:0] w0_i,
    input  logic [31:0] w1_i,
    input  logic [31:0] w9_i,
    input  logic [31:0] w14_i,
    output logic [31:0] new_o
);

    // Carries past bit 31 fall off naturally in the 32-bit sum.
    assign new_o = sigma1_small(w14_i) + w9_i + sigma0_small(w1_i) + w0_i;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Expands a 512-bit padded block into W[0..NUM_WORDS-1] from a 16-word sliding window.
// W[0] valid the cycle after load; one word per advance; advance=0 stalls with outputs held.
// Optional sticky load_err output when SHA256_MSG_SCHED_LOADERR_EN is defined.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = 64,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [511:0]      processedMsg,
    input  logic              load,
    input  logic              advance,
    output logic [WORD_W-1:0] w_out,
    output logic [5:0]        w_index,
    output logic              w_valid,
    output logic              busy,
    output logic              done
`ifdef SHA256_MSG_SCHED_LOADERR_EN
    ,
    output logic              load_err
`endif
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    sched_state_t state_q, state_d;
    word_t        win_q [SHA256_WINDOW];
    word_t        win_d [SHA256_WINDOW];
    logic [5:0]   idx_q, idx_d;
    logic         w_valid_q, w_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         load_err_q, load_err_d;
    word_t        new_w;

    sha256_sched_word u_sched_word (
        .w0_i  (win_q[0]),
        .w1_i  (win_q[1]),
        .w9_i  (win_q[9]),
        .w14_i (win_q[14]),
        .new_o (new_w)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        idx_d      = idx_q;
        load_err_d = load_err_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    for (int i = 0; i < SHA256_WINDOW; i++) begin
                        win_d[i] = processedMsg[511 - 32*i -: 32];
                    end
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        for (int i = 0; i < SHA256_WINDOW - 1; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[SHA256_WINDOW-1] = new_w;
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load outside IDLE flags an error; an accepted load clears it.
        if (load) begin
            load_err_d = (state_q != IDLE);
        end

        w_valid_d = (state_d == RUN);
        busy_d    = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            for (int i = 0; i < SHA256_WINDOW; i++) begin
                win_q[i] <= '0;
            end
            idx_q      <= '0;
            w_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            idx_q      <= idx_d;
            w_valid_q  <= w_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign w_out   = win_q[0];
    assign w_index = idx_q;
    assign w_valid = w_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef SHA256_MSG_SCHED_LOADERR_EN
    assign load_err = load_err_q;
`else
    logic unused_load_err;
    assign unused_load_err = load_err_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: directed block sequence with random data and advance patterns,
// compared against a plain-arithmetic SHA-256 schedule model.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [511:0] processed_msg;
    logic         load;
    logic         advance;
    logic [31:0]  w_out;
    logic [5:0]   w_index;
    logic         w_valid;
    logic         busy;
    logic         done;
`ifdef SHA256_MSG_SCHED_LOADERR_EN
    logic         load_err;
`endif

    always #5 clk = ~clk;

    sha256_msg_schedule #(.NUM_WORDS(64), .WORD_W(32)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .processedMsg (processed_msg),
        .load         (load),
        .advance      (advance),
        .w_out        (w_out),
        .w_index      (w_index),
        .w_valid      (w_valid),
        .busy         (busy),
        .done         (done)
`ifdef SHA256_MSG_SCHED_LOADERR_EN
        ,
        .load_err     (load_err)
`endif
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        err_exp      = 1'b0;
    logic [31:0] exp_w [64];

    logic [511:0] abc_blk;
    logic [511:0] ones_blk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Reference schedule straight from the SHA-256 definition.
    task automatic build_model(input logic [511:0] m);
        longint s;
        for (int t = 0; t < 16; t++) exp_w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s = longint'({32'd0, ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10)})
              + longint'({32'd0, exp_w[t-7]})
              + longint'({32'd0, ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3)})
              + longint'({32'd0, exp_w[t-16]});
            exp_w[t] = s[31:0];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One clock: predict the sticky load error, then land 1 time unit after the edge.
    task automatic step(input bit in_idle);
        if (load) err_exp = in_idle ? 1'b0 : 1'b1;
        if (!n_rst) err_exp = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, w_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
`ifdef SHA256_MSG_SCHED_LOADERR_EN
        check({tag, "_lderr"}, load_err, err_exp);
`endif
    endtask

    task automatic run_block(input logic [511:0] msg, input bit rnd_adv, input int load_at,
                             input int rst_at, input bit load_hold, input bit done_load);
        int t;
        int cyc;
        bit adv;
        build_model(msg);
        processed_msg = msg;
        load          = 1'b1;
        advance       = 1'($urandom % 2);
        step(1'b1);
        processed_msg = rand_block();
        load          = load_hold;
        t   = 0;
        cyc = 0;
        while (t < 64 && cyc < 400) begin
            check("run_valid", w_valid, 1'b1);
            check("run_busy", busy, 1'b1);
            check("run_done", done, 1'b0);
            check("w_index", w_index, t);
            check("w_out", w_out, exp_w[t]);
`ifdef SHA256_MSG_SCHED_LOADERR_EN
            check("run_lderr", load_err, err_exp);
`endif
            if (msg == abc_blk && t == 16) check("abc_w16", w_out, 32'h61626380);
            if (msg == abc_blk && t == 17) check("abc_w17", w_out, 32'h000F0000);
            if (msg == ones_blk && t == 16) check("ones_w16", w_out, 32'h203FFFFC);
            if (t == rst_at) begin
                n_rst   = 1'b0;
                load    = 1'b0;
                advance = 1'($urandom % 2);
                step(1'b0);
                n_rst   = 1'b1;
                advance = 1'b0;
                check_idle("rst");
                check("rst_index", w_index, 6'd0);
                check("rst_wout", w_out, 32'd0);
                return;
            end
            if (t == load_at) begin
                load          = 1'b1;
                processed_msg = rand_block();
            end
            adv     = rnd_adv ? ($urandom % 3 != 0) : 1'b1;
            advance = adv;
            step(1'b0);
            load = load_hold;
            if (adv) t++;
            cyc++;
        end
        check("block_len", t, 64);
        check("done_pulse", done, 1'b1);
        check("done_valid", w_valid, 1'b0);
        check("done_busy", busy, 1'b0);
`ifdef SHA256_MSG_SCHED_LOADERR_EN
        check("done_lderr", load_err, err_exp);
`endif
        if (done_load) begin
            load          = 1'b1;
            processed_msg = rand_block();
        end
        advance = 1'($urandom % 2);
        step(1'b0);
        load = load_hold;
        check_idle("post_done");
        if (done_load) begin
            step(1'b1);
            check_idle("done_load_ignored");
        end
        advance = 1'b0;
    endtask

    initial begin
        abc_blk  = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        ones_blk = '1;

        n_rst         = 1'b0;
        load          = 1'b0;
        advance       = 1'b0;
        processed_msg = rand_block();
        step(1'b1);
        step(1'b1);
        n_rst = 1'b1;
        check_idle("reset");
        check("reset_index", w_index, 6'd0);
        check("reset_wout", w_out, 32'd0);

        // advance while idle must not start anything
        advance = 1'b1;
        step(1'b1);
        advance = 1'b0;
        check_idle("idle_adv");
        check("idle_adv_index", w_index, 6'd0);

        run_block(abc_blk, 1'b0, -1, -1, 1'b0, 1'b0);
        run_block(abc_blk, 1'b1, -1, -1, 1'b0, 1'b0);
        run_block(abc_blk, 1'b1, 20, -1, 1'b0, 1'b0);
        run_block(abc_blk, 1'b0, -1, 37, 1'b0, 1'b0);
        run_block(abc_blk, 1'b0, -1, -1, 1'b0, 1'b0);
        run_block(ones_blk, 1'b0, -1, -1, 1'b0, 1'b0);
        run_block(rand_block(), 1'b0, -1, -1, 1'b0, 1'b1);
        run_block(rand_block(), 1'b0, -1, -1, 1'b1, 1'b0);
        run_block(rand_block(), 1'b1, -1, -1, 1'b1, 1'b0);
        run_block(rand_block(), 1'b0, -1, -1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) run_block(rand_block(), 1'b1, -1, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
